// File: rtl/max_pool_1_pkg.sv
// ---------------------------------------------------------------------------
// max_pool_1_pkg
// Shared definitions for the LeNet pooling stage and its neighbours:
// activation width, default feature-map size and the signed pixel type.
// ---------------------------------------------------------------------------
package max_pool_1_pkg;

    localparam int DATA_SIZE = 8;
    localparam int IMG_W_DEF = 24;
    localparam int IMG_H_DEF = 24;

    typedef logic signed [DATA_SIZE-1:0] pixel_t;

endpackage

// File: rtl/max_pool_1_if.sv
// ---------------------------------------------------------------------------
// max_pool_1_if
// Pixel stream in / pooled stream out for max_pool_1.
//   din_valid  : din carries a pixel this cycle
//   din        : signed pixel, raster order
//   dout_valid : one-cycle pulse per pooled result
//   dout       : signed 2x2 maximum, held between pulses
//   frame_done : pulse coinciding with the last pooled result of a frame
// master = pixel producer / result consumer, slave = pooling block.
// ---------------------------------------------------------------------------
interface max_pool_1_if #(
    parameter int DATA_SIZE = max_pool_1_pkg::DATA_SIZE
);

    logic                        din_valid;
    logic signed [DATA_SIZE-1:0] din;
    logic                        dout_valid;
    logic signed [DATA_SIZE-1:0] dout;
    logic                        frame_done;

    modport master (
        output din_valid,
        output din,
        input  dout_valid,
        input  dout,
        input  frame_done
    );

    modport slave (
        input  din_valid,
        input  din,
        output dout_valid,
        output dout,
        output frame_done
    );

endinterface

// File: rtl/max_pool_1_max2_s.sv
// ---------------------------------------------------------------------------
// max2_s
// Combinational signed maximum of two DATA_SIZE values.
//   a, b : signed operands
//   y    : max(a, b); on a tie either operand is the same value
// ---------------------------------------------------------------------------
module max2_s #(
    parameter int DATA_SIZE = max_pool_1_pkg::DATA_SIZE
) (
    input  logic signed [DATA_SIZE-1:0] a,
    input  logic signed [DATA_SIZE-1:0] b,
    output logic signed [DATA_SIZE-1:0] y
);

    assign y = (a >= b) ? a : b;

endmodule

// File: rtl/max_pool_1.sv
// ---------------------------------------------------------------------------
// max_pool_1
// 2x2, stride-2 max pooling over a raster-order single-channel feature map.
// Even rows fold each horizontal pair into a half-width line buffer; odd
// rows fold their pair with the stored value and emit one result per window.
// Optional fused ReLU: define MAX_POOL_RELU_EN to clamp negative inputs to 0.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : max_pool_1_if.slave (din_valid/din in, dout_valid/dout/frame_done out)
// ---------------------------------------------------------------------------
module max_pool_1 #(
    parameter int DATA_SIZE = max_pool_1_pkg::DATA_SIZE,
    parameter int IMG_W     = max_pool_1_pkg::IMG_W_DEF,
    parameter int IMG_H     = max_pool_1_pkg::IMG_H_DEF
) (
    input  logic        clk,
    input  logic        rst,
    max_pool_1_if.slave bus
);

    import max_pool_1_pkg::*;

    localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_D = IMG_W / 2;
    localparam int LBW  = (LB_D > 1) ? $clog2(LB_D) : 1;

    logic [CW-1:0]               col;
    logic [RW-1:0]               row;
    logic signed [DATA_SIZE-1:0] h_reg;
    logic signed [DATA_SIZE-1:0] pix_in;
    logic signed [DATA_SIZE-1:0] hmax;
    logic signed [DATA_SIZE-1:0] vmax;
    logic signed [DATA_SIZE-1:0] lb_rd;
    logic signed [DATA_SIZE-1:0] linebuf [LB_D];
    logic [LBW-1:0]              lb_idx;
    logic                        col_last;
    logic                        row_last;
    logic                        lb_we;

`ifdef MAX_POOL_RELU_EN
    assign pix_in = bus.din[DATA_SIZE-1] ? '0 : bus.din;
`else
    assign pix_in = bus.din;
`endif

    assign lb_idx   = LBW'(col >> 1);
    assign lb_rd    = linebuf[lb_idx];
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign lb_we    = !rst && bus.din_valid && col[0] && !row[0];

    max2_s #(.DATA_SIZE(DATA_SIZE)) u_hmax (
        .a (h_reg),
        .b (pix_in),
        .y (hmax)
    );

    max2_s #(.DATA_SIZE(DATA_SIZE)) u_vmax (
        .a (lb_rd),
        .b (hmax),
        .y (vmax)
    );

    // Every entry is rewritten in an even row before the odd row reads it,
    // so the array carries no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= hmax;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col            <= '0;
            row            <= '0;
            h_reg          <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.dout_valid <= 1'b0;
            bus.frame_done <= 1'b0;
            if (bus.din_valid) begin
                if (!col[0]) begin
                    h_reg <= pix_in;
                end else if (row[0]) begin
                    bus.dout       <= vmax;
                    bus.dout_valid <= 1'b1;
                    bus.frame_done <= row_last && col_last;
                end

                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_1.sv
module tb_max_pool_1;

    import max_pool_1_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    max_pool_1_if #(.DATA_SIZE(8)) bus ();

    max_pool_1 #(.DATA_SIZE(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    int     mr    = 0;
    int     mc    = 0;
    int     fd_cnt = 0;
    pixel_t img [H][W];
    pixel_t held = '0;
    int     got_q [$];

    function automatic pixel_t relu(input pixel_t p);
`ifdef MAX_POOL_RELU_EN
        return (p < 0) ? pixel_t'(0) : p;
`else
        return p;
`endif
    endfunction

    function automatic pixel_t mx(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance, update the image model, check outputs.
    task automatic step(input bit v, input pixel_t d, input bit r);
        bit     ev;
        bit     ef;
        bus.din_valid = v;
        bus.din       = d;
        rst           = r;
        @(posedge clk);
        #1;
        ev = 1'b0;
        ef = 1'b0;
        if (r) begin
            mr   = 0;
            mc   = 0;
            held = '0;
        end else if (v) begin
            img[mr][mc] = relu(d);
            if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                ev   = 1'b1;
                held = mx(mx(img[mr-1][mc-1], img[mr-1][mc]), mx(img[mr][mc-1], img[mr][mc]));
                ef   = (mr == H - 1) && (mc == W - 1);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
        chk("dout_valid", {7'd0, bus.dout_valid}, {7'd0, ev});
        chk("dout", bus.dout, held);
        chk("frame_done", {7'd0, bus.frame_done}, {7'd0, ef});
        if (bus.dout_valid === 1'b1) got_q.push_back(int'(bus.dout));
        if (bus.frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic send_frame(input int base, input int gmax);
        for (int i = 0; i < W * H; i++) begin
            step(1'b1, pixel_t'(base + i), 1'b0);
            repeat ($urandom_range(0, gmax)) step(1'b0, pixel_t'($urandom), 1'b0);
        end
    endtask

    task automatic chk_q(input string tag, input int exp [$]);
        chk_int({tag, "_count"}, got_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < got_q.size()) chk_int(tag, got_q[i], exp[i]);
        end
    endtask

    initial begin
        int     e [$];
        pixel_t fr [W*H];

        bus.din_valid = 1'b0;
        bus.din       = '0;

        // reset state
        step(1'b0, '0, 1'b1);
        step(1'b1, 8'sh33, 1'b1);
        step(1'b0, '0, 1'b0);

        // continuous 0..15
        got_q.delete(); fd_cnt = 0;
        send_frame(0, 0);
        e = '{5, 7, 13, 15};
        chk_q("ramp", e);
        chk_int("ramp_fd", fd_cnt, 1);

        // same frame with valid gaps
        got_q.delete(); fd_cnt = 0;
        send_frame(0, 5);
        chk_q("gaps", e);
        chk_int("gaps_fd", fd_cnt, 1);

        // back-to-back frames
        got_q.delete(); fd_cnt = 0;
        send_frame(0, 0);
        send_frame(16, 0);
        e = '{5, 7, 13, 15, 21, 23, 29, 31};
        chk_q("b2b", e);
        chk_int("b2b_fd", fd_cnt, 2);

        // reset after pixel 9 (reset coincides with a valid pixel, which is dropped)
        for (int i = 0; i < 10; i++) step(1'b1, pixel_t'(i), 1'b0);
        step(1'b1, 8'sh55, 1'b1);
        step(1'b0, '0, 1'b0);
        got_q.delete(); fd_cnt = 0;
        send_frame(0, 0);
        e = '{5, 7, 13, 15};
        chk_q("rst_mid", e);
        chk_int("rst_mid_fd", fd_cnt, 1);

        // negative window
        foreach (fr[i]) fr[i] = pixel_t'($urandom);
        fr[0] = -8'sd3;
        fr[1] = -8'sd8;
        fr[4] = -8'sd1;
        fr[5] = -8'sd128;
        got_q.delete();
        for (int i = 0; i < W * H; i++) step(1'b1, fr[i], 1'b0);
`ifdef MAX_POOL_RELU_EN
        chk_int("neg_win", (got_q.size() > 0) ? got_q[0] : 999, 0);
`else
        chk_int("neg_win", (got_q.size() > 0) ? got_q[0] : 999, -1);
`endif

        // all-equal 0x7F
        got_q.delete();
        for (int i = 0; i < W * H; i++) step(1'b1, 8'sh7F, 1'b0);
        e = '{127, 127, 127, 127};
        chk_q("eq7f", e);

        // random frames with random gaps
        got_q.delete(); fd_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < W * H; i++) begin
                step(1'b1, pixel_t'($urandom), 1'b0);
                repeat ($urandom_range(0, 3)) step(1'b0, pixel_t'($urandom), 1'b0);
            end
        end
        chk_int("rand_count", got_q.size(), 12);
        chk_int("rand_fd", fd_cnt, 3);

        repeat (3) step(1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max_pool_1.md
MAX_POOL_1 -- requirements
Module: max_pool_1

Interface
REQ-001 The block SHALL have parameter `DATA_SIZE`, default 8, the activation width in bits.
REQ-002 The block SHALL have parameter `IMG_W`, default 24, the input feature-map width in pixels; it SHALL be even and at least 2.
REQ-003 The block SHALL have parameter `IMG_H`, default 24, the input feature-map height in pixels; it SHALL be even and at least 2.
REQ-004 The block SHALL have port `clk`, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port `din_valid`, input, 1 bit: `din` carries a pixel this cycle.
REQ-007 The block SHALL have port `din`, input, `DATA_SIZE` bits: signed two's-complement pixel, raster order, row-major, one channel.
REQ-008 The block SHALL have port `dout_valid`, output, 1 bit: one-cycle pulse marking a pooled result.
REQ-009 The block SHALL have port `dout`, output, `DATA_SIZE` bits: signed 2x2 maximum.
REQ-010 The block SHALL have port `frame_done`, output, 1 bit: one-cycle pulse that coincides with the last pooled result of a frame.

Function
REQ-011 The block SHALL perform 2x2 max pooling with stride 2, producing an output map of `IMG_W`/2 x `IMG_H`/2 in raster order.
REQ-012 Column counter `col` (0..`IMG_W`-1) and row counter `row` (0..`IMG_H`-1) SHALL advance only on cycles where `din_valid`=1; otherwise all state SHALL hold.
REQ-013 When `din_valid`=1 and `col` is even, the block SHALL store `din` in horizontal register `h_reg`.
REQ-014 When `din_valid`=1 and `col` is odd, the block SHALL form `hmax`=max(`h_reg`, `din`) using a signed compare.
REQ-015 On an odd `col` in an even `row`, the block SHALL write `hmax` into line buffer entry `col`>>1; the buffer has depth `IMG_W`/2 and width `DATA_SIZE`.
REQ-016 On an odd `col` in an odd `row`, the block SHALL register `dout`=max(`linebuf[col>>1]`, `hmax`) and assert `dout_valid` on the next cycle.
REQ-017 Latency SHALL be exactly 1 cycle, measured from the accepting edge of the fourth pixel of a window to `dout_valid`.
REQ-018 `dout_valid` SHALL be high for exactly one cycle per window; `dout` SHALL hold its last value while `dout_valid`=0.
REQ-019 When two compared values are equal, the result SHALL be that value; no tie-priority is observable.
REQ-020 At `col`=`IMG_W`-1, `col` SHALL wrap to 0 and `row` SHALL increment.
REQ-021 At `row`=`IMG_H`-1 and `col`=`IMG_W`-1, both counters SHALL wrap to 0, so the next frame may follow back-to-back with no idle cycle.
REQ-022 `frame_done` SHALL assert in the same cycle as the `dout_valid` for output (`IMG_W`/2-1, `IMG_H`/2-1).
REQ-023 Gaps in `din_valid` of any length, including mid-window and mid-row, SHALL NOT change any result.
REQ-024 The block SHALL have no backpressure: the consumer must accept every `dout_valid` pulse.

Reset
REQ-025 While `rst`=1, the block SHALL clear `col`, `row`, `h_reg`, `dout`, `dout_valid` and `frame_done` to 0 on the clock edge.
REQ-026 Line-buffer contents SHALL NOT require reset, since every entry is written in an even row before it is read in an odd row.
REQ-027 When `rst` is asserted mid-frame, the partial frame SHALL be discarded; the first `din_valid` after reset SHALL be treated as pixel (0,0).
REQ-028 When `rst` and `din_valid` are both 1 in the same cycle, reset SHALL win and the pixel SHALL be dropped.

Configuration
REQ-029 When macro `MAX_POOL_RELU_EN` is defined, each input SHALL be clamped to 0 if its MSB=1 before any compare, so `dout` is never negative (fused ReLU).
REQ-030 When `MAX_POOL_RELU_EN` is undefined, `din` SHALL be used unmodified and negative results SHALL pass through.

Structure
REQ-031 A shared package SHALL hold `DATA_SIZE` and a signed pixel typedef, shared with neighbouring LeNet stages.
REQ-032 One sub-module, `max2_s`, SHALL implement the combinational signed max of two `DATA_SIZE` values; it SHALL be instantiated twice, once for the horizontal max and once for the vertical max.
REQ-033 The line buffer SHALL be an inferred register array inside `max_pool_1`, with no memory macro.

Verification
REQ-034 Use `IMG_W`=`IMG_H`=4 and stream pixels 0..15 continuously; expect `dout`=5, 7, 13, 15, each one cycle after pixels 5, 7, 13 and 15 are accepted, with `frame_done` on 15.
REQ-035 Send a window of {-3, -8, -1, -128} with the macro undefined; expect `dout`=-1. With `MAX_POOL_RELU_EN` defined, expect `dout`=0.
REQ-036 Repeat REQ-034 with random `din_valid` gaps of 0-5 cycles; expect identical outputs and no extra `dout_valid` pulses.
REQ-037 Send two frames back-to-back with the second frame = first + 16; expect the second frame's outputs 21, 23, 29, 31 with a second `frame_done`.
REQ-038 Assert `rst` after pixel 9, then send a fresh 4x4 frame; expect exactly 4 outputs matching REQ-034 and no output from the old partial frame.
REQ-039 Send a window of all-equal values 0x7F; expect `dout`=0x7F, confirming no signed-overflow in the compare.
